// File: rtl/calc_ctrl_param.sv
// calc_ctrl_param: calculator control FSM (IDLE/OP/CONV/RES), op selector and sequential BCD conversion.
// Latency: binary ops reach RES 2 cycles after enter; arithmetic ops reach RES 2W+2 cycles after enter (busy for 2W+1).
// Backpressure: none; button pulses arriving while busy are dropped, never queued.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   enter, back, up, down    single-cycle button pulses (debounced, edge-detected)
//   res[2W-1:0]              two's-complement result from the combinational datapath
//   op[OPW-1:0]              current operation index
//   mode[1:0]                0 ZEROS, 1 OP, 2 RESULT, 3 ERROR
//   digits[4*DIGITS-1:0]     BCD digits, digit 0 least significant in [3:0]
//   neg                      displayed result is negative
//   busy                     conversion in progress
//
// Optional feature macro: CALC_CTRL_NEG_EN (signed arithmetic results, shown as magnitude + neg).

module calc_ctrl_param #(
  parameter int W         = 4,
  parameter int DIGITS    = 4,
  parameter int NUM_OPS   = 8,
  parameter int LOGIC_OPS = 4,
  localparam int OPW      = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enter,
  input  logic                  back,
  input  logic                  up,
  input  logic                  down,
  input  logic [2*W-1:0]        res,
  output logic [OPW-1:0]        op,
  output logic [1:0]            mode,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  neg,
  output logic                  busy
);

  localparam int RW     = 2 * W;
  localparam int BW     = 4 * DIGITS;
  localparam int CW     = $clog2(RW + 1);
  // Number of digits fed from res bits in binary display mode.
  localparam int NB     = (DIGITS < RW) ? DIGITS : RW;

  localparam logic [OPW:0]   LOGIC_LIM = LOGIC_OPS[OPW:0];
  localparam logic [OPW-1:0] OP_MAX    = OPW'(NUM_OPS - 1);
  localparam logic [CW-1:0]  SHIFTS    = CW'(RW);

  localparam logic [1:0] MODE_ZEROS  = 2'd0;
  localparam logic [1:0] MODE_OP     = 2'd1;
  localparam logic [1:0] MODE_RESULT = 2'd2;
  localparam logic [1:0] MODE_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_CONV = 2'd2,
    S_RES  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [1:0]      mode_q, mode_d;
  logic [BW-1:0]   digits_q, digits_d;
  logic            neg_q, neg_d;
  logic            err_q, err_d;
  logic            have_res_q, have_res_d;   // a conversion has completed since reset
  logic [RW-1:0]   bin_q, bin_d;             // binary shift register (or raw res for bitwise ops)
  logic [BW-1:0]   bcd_q, bcd_d;             // double-dabble accumulator
  logic [CW-1:0]   cnt_q, cnt_d;             // shifts performed
  logic            ovf_q, ovf_d;             // sticky: a 1 was shifted past the top digit
  logic            is_bin_q, is_bin_d;
  logic            neg_pend_q, neg_pend_d;   // sign of the value being converted

  logic            sign_w;
  logic [RW-1:0]   mag_w;
  logic            is_bin_now;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bin_digits;
  logic            start;
  logic            go_idle;

  // Magnitude of the incoming result; with the feature off res is plain unsigned.
`ifdef CALC_CTRL_NEG_EN
  always_comb begin
    sign_w = res[RW-1];
    mag_w  = sign_w ? -res : res;
  end
`else
  always_comb begin
    sign_w = 1'b0;
    mag_w  = res;
  end
`endif

  assign is_bin_now = ({1'b0, op_q} < LOGIC_LIM);

  // Add-3 correction on every digit that is 5 or more before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Bitwise ops show one res bit per digit.
  always_comb begin
    bin_digits = '0;
    for (int i = 0; i < NB; i++) begin
      bin_digits[4*i +: 4] = {3'b000, bin_q[i]};
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    digits_d   = digits_q;
    neg_d      = neg_q;
    err_d      = err_q;
    have_res_d = have_res_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    is_bin_d   = is_bin_q;
    neg_pend_d = neg_pend_q;
    mode_d     = mode_q;
    start      = 1'b0;
    go_idle    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!back) begin
          if (enter) begin
            start = 1'b1;
          end else if (up || down) begin
            state_d = S_OP;
          end
        end
      end

      S_OP: begin
        if (back) begin
          if (have_res_q) begin
            state_d = S_RES;
          end else begin
            go_idle = 1'b1;
          end
        end else if (enter) begin
          start = 1'b1;
        end else if (up) begin
          op_d = (op_q == OP_MAX) ? '0 : op_q + 1'b1;
        end else if (down) begin
          op_d = (op_q == '0) ? OP_MAX : op_q - 1'b1;
        end
      end

      S_CONV: begin
        if (is_bin_q) begin
          digits_d   = bin_digits;
          neg_d      = 1'b0;
          err_d      = 1'b0;
          have_res_d = 1'b1;
          state_d    = S_RES;
        end else if (cnt_q != SHIFTS) begin
          bcd_d = {bcd_adj[BW-2:0], bin_q[RW-1]};
          bin_d = {bin_q[RW-2:0], 1'b0};
          // Anything leaving the top digit means the value needs more digits.
          ovf_d = ovf_q | bcd_adj[BW-1];
          cnt_d = cnt_q + 1'b1;
        end else begin
          digits_d   = ovf_q ? '1 : bcd_q;
          err_d      = ovf_q;
          neg_d      = neg_pend_q;
          have_res_d = 1'b1;
          state_d    = S_RES;
        end
      end

      S_RES: begin
        if (back) begin
          go_idle = 1'b1;
        end else if (enter) begin
          start = 1'b1;
        end else if (up || down) begin
          state_d = S_OP;
        end
      end

      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (go_idle) begin
      state_d  = S_IDLE;
      op_d     = '0;
      digits_d = '0;
      neg_d    = 1'b0;
      err_d    = 1'b0;
    end

    // Conversion start: capture res now so later res changes cannot leak in.
    if (start) begin
      state_d    = S_CONV;
      is_bin_d   = is_bin_now;
      bin_d      = is_bin_now ? res : mag_w;
      neg_pend_d = ~is_bin_now & sign_w;
      bcd_d      = '0;
      cnt_d      = '0;
      ovf_d      = 1'b0;
    end

    // Mode follows the next state; during CONV the previous mode is kept.
    case (state_d)
      S_IDLE:  mode_d = MODE_ZEROS;
      S_OP:    mode_d = MODE_OP;
      S_RES:   mode_d = err_d ? MODE_ERROR : MODE_RESULT;
      default: mode_d = mode_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      mode_q     <= MODE_ZEROS;
      digits_q   <= '0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
      have_res_q <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      is_bin_q   <= 1'b0;
      neg_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mode_q     <= mode_d;
      digits_q   <= digits_d;
      neg_q      <= neg_d;
      err_q      <= err_d;
      have_res_q <= have_res_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      is_bin_q   <= is_bin_d;
      neg_pend_q <= neg_pend_d;
    end
  end

  assign op     = op_q;
  assign mode   = mode_q;
  assign digits = digits_q;
  assign neg    = neg_q;
  assign busy   = (state_q == S_CONV);

endmodule

// File: tb/tb_calc_ctrl_param.sv
// Directed bench for calc_ctrl_param: one default instance (4 digits) and one
// 2-digit instance sharing the same stimulus, so overflow is exercised too.
module tb_calc_ctrl_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enter = 1'b0, back = 1'b0, up = 1'b0, down = 1'b0;
  logic [7:0]  res = 8'h00;

  logic [2:0]  op_a, op_b;
  logic [1:0]  mode_a, mode_b;
  logic [15:0] dig_a;
  logic [7:0]  dig_b;
  logic        neg_a, neg_b, busy_a, busy_b;

  int vec_cnt = 0;
  int err_cnt = 0;
  int nb;

  always #5 clk = ~clk;

  calc_ctrl_param dut_a (
    .clk(clk), .rst_n(rst_n), .enter(enter), .back(back), .up(up), .down(down),
    .res(res), .op(op_a), .mode(mode_a), .digits(dig_a), .neg(neg_a), .busy(busy_a)
  );

  calc_ctrl_param #(.DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .enter(enter), .back(back), .up(up), .down(down),
    .res(res), .op(op_b), .mode(mode_b), .digits(dig_b), .neg(neg_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle pulse; returns 1ns after the edge that sampled it.
  task automatic press(input logic e, input logic b, input logic u, input logic d);
    @(negedge clk);
    enter = e; back = b; up = u; down = d;
    @(posedge clk);
    #1;
    enter = 1'b0; back = 1'b0; up = 1'b0; down = 1'b0;
  endtask

  task automatic wait_idle_busy();
    int n = 0;
    while (busy_a && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy_timeout", {31'b0, busy_a}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_op",   op_a,   0);
    chk("rst_mode", mode_a, 0);
    chk("rst_dig",  dig_a,  0);
    chk("rst_neg",  neg_a,  0);
    chk("rst_busy", busy_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap: down enters OP with op 0, second down wraps to 7, up wraps back
    press(0, 0, 0, 1);
    chk("wrap_enter_mode", mode_a, 1);
    chk("wrap_enter_op",   op_a,   0);
    press(0, 0, 0, 1);
    chk("wrap_down_op",   op_a,   7);
    chk("wrap_down_mode", mode_a, 1);
    press(0, 0, 1, 0);
    chk("wrap_up_op", op_a, 0);

    // Binary op 2, res 0000_1011
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    chk("bin_op", op_a, 2);
    res = 8'b0000_1011;
    press(1, 0, 0, 0);
    chk("bin_busy1", busy_a, 1);
    @(posedge clk); #1;
    chk("bin_busy0", busy_a, 0);
    chk("bin_mode",  mode_a, 2);
    chk("bin_dig",   dig_a,  16'h1011);
    chk("bin_neg",   neg_a,  0);
    chk("bin_dig2",  dig_b,  8'h11);

    // Arithmetic op 4, res 255: busy for 9 cycles
    press(0, 0, 1, 0);
    chk("res_to_op_op",   op_a,   2);
    chk("res_to_op_mode", mode_a, 1);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    res = 8'd255;
    press(1, 0, 0, 0);
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy_a) nb++;
      @(posedge clk); #1;
    end
    chk("ar_busy_cycles", nb, 9);
    chk("ar_mode",  mode_a, 2);
    chk("ar_dig",   dig_a,  16'h0255);
    chk("ar_neg",   neg_a,  0);
    chk("ovf255_mode", mode_b, 3);
    chk("ovf255_dig",  dig_b,  8'hFF);

    // Negative result with up/enter dropped mid-conversion
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    chk("neg_op", op_a, 5);
    res = 8'hF9;
    nb = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      enter = (cyc == 0) || (cyc == 4);
      up    = (cyc == 2);
      @(posedge clk); #1;
      if (busy_a) nb++;
    end
    enter = 1'b0; up = 1'b0;
    chk("drop_busy_cycles", nb, 9);
    chk("drop_op",   op_a,   5);
    chk("neg_mode",  mode_a, 2);
`ifdef CALC_CTRL_NEG_EN
    chk("neg_dig",   dig_a,  16'h0007);
    chk("neg_neg",   neg_a,  1);
    chk("neg_dig2",  dig_b,  8'h07);
    chk("neg_mode2", mode_b, 2);
`else
    chk("neg_dig",   dig_a,  16'h0249);
    chk("neg_neg",   neg_a,  0);
    chk("neg_dig2",  dig_b,  8'hFF);
    chk("neg_mode2", mode_b, 3);
`endif

    // Overflow on 2-digit instance with 150, then back clears
    res = 8'd150;
    press(1, 0, 0, 0);
    wait_idle_busy();
    chk("ovf_mode2", mode_b, 3);
    chk("ovf_dig2",  dig_b,  8'hFF);
`ifdef CALC_CTRL_NEG_EN
    chk("ovf_dig",   dig_a,  16'h0106);
    chk("ovf_negA",  neg_a,  1);
`else
    chk("ovf_dig",   dig_a,  16'h0150);
    chk("ovf_negA",  neg_a,  0);
`endif
    press(0, 1, 0, 0);
    chk("back_mode2", mode_b, 0);
    chk("back_dig2",  dig_b,  0);
    chk("back_mode",  mode_a, 0);
    chk("back_dig",   dig_a,  0);
    chk("back_op",    op_a,   0);

    // Binary op 0 from IDLE, then back+enter together in RES
    press(1, 0, 0, 0);
    @(posedge clk); #1;
    chk("b0_mode", mode_a, 2);
    chk("b0_dig",  dig_a,  16'h0110);
    chk("b0_dig2", dig_b,  8'h10);
    press(1, 1, 0, 0);
    chk("prio_mode", mode_a, 0);
    chk("prio_busy", busy_a, 0);
    chk("prio_dig",  dig_a,  0);

    // Reset during conversion cycle 4
    press(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) press(0, 0, 1, 0);
    chk("rc_op", op_a, 4);
    res = 8'd255;
    press(1, 0, 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rc_busy_pre", busy_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rc_busy", busy_a, 0);
    chk("rc_op0",  op_a,   0);
    chk("rc_mode", mode_a, 0);
    chk("rc_dig",  dig_a,  0);
    @(negedge clk);
    rst_n = 1'b1;
    // Captured-result flag cleared: back from OP returns to IDLE
    press(0, 0, 1, 0);
    chk("rc_op_mode", mode_a, 1);
    press(0, 1, 0, 0);
    chk("rc_back_mode", mode_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/calc_ctrl_param.md
# calc_ctrl_param

Parametrised control unit for the calculator datapath. It owns the operation selector and the enter/back/up/down menu state machine. It captures the datapath result and converts it to per-digit BCD with an internal sequential double-dabble engine. It hands packed digit codes plus a display mode to the seven-segment encode/multiplex stage. It sits between the edge-detected button pulses and the display driver, and generalises operand width, digit count and operation count, with overflow and negative-result handling.

## Interface

- W, default 4: operand width; result input is 2W bits.
- DIGITS, default 4: number of BCD display digits.
- NUM_OPS, default 8: number of selectable operations; op counter wraps modulo NUM_OPS.
- LOGIC_OPS, default 4: ops with index < LOGIC_OPS are bitwise and are displayed as binary digits.
- OPW, default $clog2(NUM_OPS): op code width (localparam).

Ports:

- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- enter, back, up, down  in  1 each  single-cycle pulses, already debounced and edge-detected.
- res  in  2W  two's-complement result from the combinational calculator; a function of a, b and op.
- op  out  OPW  current operation; reset 0.
- mode  out  2  display mode: 0 ZEROS, 1 OP, 2 RESULT, 3 ERROR; reset 0.
- digits  out  4*DIGITS  BCD digits, digit 0 in [3:0] is least significant; reset all 0.
- neg  out  1  the displayed result is negative; reset 0.
- busy  out  1  high while in CONV; reset 0.

## Operation

States:
- IDLE
- OP
- CONV
- RES

Reset state is IDLE.

Event priority on the same cycle is back > enter > up/down; only the highest-priority event acts.

- **IDLE:** mode=ZEROS, op held at 0.
  - enter → CONV.
  - up or down → OP; op is unchanged by that pulse.
- **OP:** mode=OP.
  - up: op ← op+1, wrapping NUM_OPS-1 → 0.
  - down: op ← op−1, wrapping 0 → NUM_OPS-1.
  - enter → CONV.
  - back → RES if a result has been captured since reset, else IDLE.
- **CONV:** busy=1. All button pulses are ignored.
  - Entry cycle: latch res into the shift register.
  - Binary ops (op < LOGIC_OPS): digit i ← {3'b0, res[i]} for i < min(DIGITS, 2W); remaining digits are 0. Done in 1 cycle.
  - Arithmetic ops: magnitude = |res| if the NEG feature is enabled and res[2W-1]=1, else res taken as unsigned. Double-dabble runs one bit per cycle for 2W cycles.
  - Overflow: magnitude ≥ 10^DIGITS sets the error flag and mode=ERROR in RES; digits are all 4'hF.
- **RES:** mode=RESULT, or ERROR on overflow. digits/neg hold their captured values and do not follow changes on res.
  - back → IDLE and clears digits/neg.
  - enter → CONV, re-converting with the current res.
  - up or down → OP; op is unchanged.
- digits and neg change only on the last CONV cycle and on IDLE entry.

## Timing

- enter sampled at edge n → busy=1 from n+1.
- Binary op: RES, with valid digits, from edge n+2.
- Arithmetic op: RES from edge n+2W+2. Latch takes 1 cycle, shifts take 2W cycles, overflow/sign check takes 1 cycle.
- busy falls on the same edge that mode becomes RESULT or ERROR.
- up/down in OP updates op on the next edge; res reflects the new op combinationally.
- rst_n low mid-CONV: all outputs return to reset values asynchronously. The conversion is discarded and the captured-result flag is cleared.
- Pulses arriving while busy are dropped and are not queued.

## Configuration

- **CALC_CTRL_NEG_EN defined:** res is treated as signed for arithmetic ops.
  - Negative values are converted as a magnitude.
  - neg=1 in RES.
  - The overflow check uses the magnitude.
- **CALC_CTRL_NEG_EN undefined:**
  - res is always unsigned.
  - neg is tied to 0.
  - A negative subtraction result therefore shows its unsigned value, or ERROR if it overflows.

## Test plan

Defaults W=4, DIGITS=4, NUM_OPS=8, LOGIC_OPS=4.

- **Reset and wrap:** reset, then down pulse, then down pulse → state OP, op=7; then up → op=0. mode=1 throughout OP.
- **Binary op:** op=2, res=8'b0000_1011, enter → busy for 1 cycle; RES with digits=16'h1011, mode=2, neg=0, two cycles after enter.
- **Arithmetic op:** op=4, res=8'd255, enter → busy=1 for exactly 9 cycles; then digits=16'h0255, mode=2.
- **Negative result:**
  - With CALC_CTRL_NEG_EN: op=5, res=8'hF9 → digits=16'h0007, neg=1.
  - Without it: digits=16'h0249, neg=0.
- **Overflow:** DIGITS=2, op=4, res=8'd150 → mode=3, digits=8'hFF. A following back pulse → IDLE, mode=0, digits=0.
- **Drop, priority and reset:**
  - up and enter pulsed during CONV → ignored; op unchanged.
  - back and enter pulsed in the same cycle in RES → IDLE.
  - rst_n asserted at CONV cycle 4 → immediate IDLE, busy=0, op=0.
